// File: rtl/dm_lsu.sv
// Load/store initiator between the M-stage register and a word-wide data memory.
// Optional build macro DM_LSU_MISALIGN_ERR_EN: misaligned half/word accesses report resp_err.
module dm_lsu #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [31:0]       mem_pc,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_wa,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

   state_t      state;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        unused_addr;

   // Bits above the memory depth wrap, so they are deliberately dropped.
   assign unused_addr = ^req_addr[31:ADDR_W+2];

`ifdef DM_LSU_MISALIGN_ERR_EN
   logic misaligned;
   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   assign req_err    = (req_size == 2'b11) || misaligned;
`else
   // Half lanes only look at addr[1] and word accesses ignore the lane, which
   // gives force-alignment without extra logic.
   assign req_err    = (req_size == 2'b11);
`endif

   assign req_ready  = (state == IDLE) && reset;
   assign resp_valid = (state == RESP);
   assign mem_we     = (state == WRITE);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      byte_v    = mem_rd[{lane_q, 3'b000} +: 8];
      half_v    = mem_rd[{lane_q[1], 4'b0000} +: 16];
      load_data = mem_rd;
      case (size_q)
         2'b00:   load_data = {{24{sign_q & byte_v[7]}}, byte_v};
         2'b01:   load_data = {{16{sign_q & half_v[15]}}, half_v};
         default: load_data = mem_rd;
      endcase
   end

   always_comb begin
      merge_data = mem_rd;
      case (size_q)
         2'b00:   merge_data[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
         2'b01:   merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merge_data = mem_rd;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         size_q     <= 2'b00;
         sign_q     <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         mem_pc     <= 32'h0;
         mem_wa     <= '0;
         mem_wd     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_q  <= req_size;
                  sign_q  <= req_sign;
                  lane_q  <= req_addr[1:0];
                  wdata_q <= req_wdata;
                  mem_wa  <= req_addr[ADDR_W+1:2];
                  mem_pc  <= req_pc;
                  if (req_err) begin
                     resp_rdata <= 32'h0;
                     resp_err   <= 1'b1;
                     state      <= RESP;
                  end else if (!req_we) begin
                     state <= LOAD;
                  end else if (req_size == 2'b10) begin
                     mem_wd <= req_wdata;
                     state  <= WRITE;
                  end else begin
                     state <= MERGE;
                  end
               end
            end
            LOAD: begin
               resp_rdata <= load_data;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            MERGE: begin
               mem_wd <= merge_data;
               state  <= WRITE;
            end
            WRITE: begin
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
